readback_framer: RTL

READBACK_FRAMER -- requirements
Module: readback_framer

---
 rtl/readback_framer.sv | 99 +++++++++
 1 files changed

// File: rtl/readback_framer.sv
// readback_framer: frames tagged byte messages into 32-bit readback FIFO words; define READBACK_CHECKSUM_EN to append a checksum trailer word
module readback_framer #(
   parameter logic [7:0] HEADER_MAGIC  = 8'hA5,
   parameter logic [7:0] TRAILER_MAGIC = 8'h5A
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic        msg_start,
   input  logic [7:0]  msg_tag,
   input  logic [7:0]  msg_len,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic [31:0] fifo_data,
   output logic        fifo_write,
   input  logic        fifo_full,
   output logic        busy,
   output logic [7:0]  drop_count
);
`ifdef READBACK_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, FLUSH, TRAILER} state_t;
   localparam state_t DONE = TRAILER;
`else
   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FLUSH} state_t;
   localparam state_t DONE = IDLE;
   logic unused_magic;
   assign unused_magic = ^TRAILER_MAGIC;
`endif
   state_t      state, state_next;
   logic [31:0] word;
   logic        pending;
   logic [7:0]  len;
   logic [7:0]  cnt;
   logic        wr;
   logic        acc;
   logic        last;
   assign wr         = pending & ~fifo_full;
   assign fifo_write = wr;
   assign fifo_data  = word;
   assign busy       = state != IDLE;
   assign byte_ready = state == PAYLOAD && !pending;
   assign acc        = byte_valid & byte_ready;
   assign last       = cnt == len - 8'd1;
   // state register
   always_ff @(posedge sys_clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_next;
   // next state: each framing phase ends when its word leaves for the FIFO
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = msg_start ? HEADER : IDLE;
         HEADER:  if (wr) state_next = (len == 8'd0) ? DONE : PAYLOAD;
         PAYLOAD: if (acc && last) state_next = FLUSH;
         FLUSH:   if (wr) state_next = DONE;
`ifdef READBACK_CHECKSUM_EN
         TRAILER: if (wr) state_next = IDLE;
`endif
         default: state_next = IDLE;
      endcase
   end
`ifdef READBACK_CHECKSUM_EN
   logic [7:0] sum;
   // running mod-256 sum of accepted payload bytes
   always_ff @(posedge sys_clk or negedge reset_n)
      if (!reset_n) sum <= '0;
      else if (state == IDLE && msg_start) sum <= '0;
      else if (acc) sum <= sum + byte_data;
`endif
   // word assembly, pending flag, byte counter and drop counter
   always_ff @(posedge sys_clk or negedge reset_n)
      if (!reset_n) begin
         word       <= '0;
         pending    <= 1'b0;
         len        <= '0;
         cnt        <= '0;
         drop_count <= '0;
      end else begin
         if (wr) pending <= 1'b0;
         if (state == IDLE && msg_start) begin
            len     <= msg_len;
            cnt     <= '0;
            word    <= {HEADER_MAGIC, msg_tag, msg_len, 8'h00};
            pending <= 1'b1;
         end
         if (acc) begin
            word <= (cnt[1:0] == 2'd0) ? {24'h0, byte_data} : word | ({24'h0, byte_data} << {cnt[1:0], 3'b000});
            cnt  <= cnt + 8'd1;
            if (cnt[1:0] == 2'd3 || last) pending <= 1'b1;
         end
`ifdef READBACK_CHECKSUM_EN
         if (state != TRAILER && state_next == TRAILER) begin
            word    <= {TRAILER_MAGIC, 16'h0000, sum};
            pending <= 1'b1;
         end
`endif
         if (msg_start && busy && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
endmodule
